freq_seg_display: RTL
=====================

// Module: freq_seg_display
// PURPOSE
//  Downstream consumer of the frequency counter's 16-bit binary reading.
//  - Converts the reading to BCD with a sequential shift-add-3 converter.
//  - Drives the Basys2 4-digit common-anode 7-segment display by time-multiplexing the digits.
//  - Readings above 9999 Hz are shown auto-ranged in kHz with a decimal point.
// PARAMETERS
//  REFRESH_DIV  12500  clk cycles each digit stays lit (50 MHz -> 4 kHz digit rate, 1 kHz frame)
//  CNT_W        14     width of the refresh prescaler; must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//  clk        in   1   system clock, 50 MHz
//  rst_n      in   1   asynchronous reset, active-low
//  freq       in   16  binary frequency in Hz, synchronous to clk
//  seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1   decimal point, active-low
//  an         out  4   digit anodes, active-low; an[3] is the leftmost digit
//  range_khz  out  1   1 = display shows kHz ("XX.XX"), 0 = Hz
//  busy       out  1   1 while a conversion is in progress
// BEHAVIOUR
//  Clock and reset: one clock (clk). rst_n is asynchronous assert, active-low; release is synchronous to clk.
//  Reset values: seg=7'h7F, dp=1, an=4'hF, range_khz=0, busy=0. Held value, BCD and display registers = 0. FSM = IDLE.
//  Converter FSM, states IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE:
//   IDLE:   if freq != held value, go to LOAD; otherwise stay.
//   LOAD:   capture freq into the shift register and the held value; clear the 20-bit BCD accumulator; busy=1.
//   SHIFT:  exactly 16 cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1.
//   COMMIT: copy all 5 BCD digits d4..d0 into the display registers in one cycle; busy=0 on the next cycle.
//   Latency: a freq change first sampled in IDLE reaches the display registers 18 cycles later.
//   A freq change during LOAD/SHIFT/COMMIT does not disturb the conversion. It is re-evaluated on return to IDLE, so the final value always converges.
//   Display registers update atomically, so a half-converted value is never shown.
//  Ranging, decided at COMMIT:
//   d4 != 0: range_khz=1. Digits 3..0 show d4 d3 d2 d1; dp lit on digit 2 only.
//     Example: 12345 shows "12.34"; 65535 shows "65.53". The last digit is truncated, not rounded.
//   d4 == 0: range_khz=0. Digits 3..0 show d3 d2 d1 d0; dp off.
//  Scan:
//   The prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index (2 bits) increments, 3 wraps to 0.
//   an is one-hot low on the indexed digit. seg and dp are registered in the same cycle as an, so there is no ghosting skew.
//   Segment decode covers 0-9. The blank code drives all segments off.
//   First digit lights REFRESH_DIV cycles after reset release, showing digit 0 = "0".
//  Reset mid-conversion: the conversion is aborted, display returns to the reset state, and the next IDLE re-converts the current freq.
// CONFIGURATION
//  FREQ_DISP_BLANK_EN defined:
//   In Hz mode, zero digits to the left of the most significant nonzero digit are blanked (seg=7'h7F, anode still scanned).
//   Digit 0 is never blanked. Example: 42 shows "  42"; 0 shows "   0".
//   kHz mode is unaffected (d4 != 0).
//  Not defined: all four digits are always shown. Example: 42 shows "0042".
// STRUCTURE
//  Package freq_disp_pkg holds:
//   - FSM state typedef {IDLE, LOAD, SHIFT, COMMIT};
//   - 7-segment constants SEG_0..SEG_9 and SEG_BLANK (active-low);
//   - localparam BIN_W=16 and BCD_DIGITS=5.
//  Sub-module bin2bcd_seq: the converter FSM plus shift/add-3 datapath.
//   Handshake: start/busy/done; outputs bcd[19:0], valid on done.
//  Scan counter, ranging mux, blanking and segment decode stay in the top module.
// TESTING (sim with REFRESH_DIV=4)
//  1. Reset: rst_n=0 -> seg=7F, an=F, dp=1, busy=0. Release with freq=0 -> after 4 cycles an=E, seg=SEG_0.
//  2. freq=1234 -> busy high 17 cycles; one full scan shows an[3..0] = 1,2,3,4; dp=1; range_khz=0.
//  3. freq=12345 -> range_khz=1; digits 1,2,3,4; dp=0 only while an=4'b1011.
//     freq=65535 -> "65.53".
//  4. freq 500 -> 9000 changed on the 5th SHIFT cycle -> display briefly commits 500, then 9000 within 18 further cycles. Never shows a mixture.
//  5. rst_n pulsed low during SHIFT -> outputs reset immediately; after release the current freq is converted from scratch.
//  6. FREQ_DISP_BLANK_EN: freq=42 -> digits 3,2 blank, digits 1,0 show 4,2. Without the macro -> "0042".

Source files
------------

// File: rtl/freq_disp_pkg.sv
// Shared types, segment codes and helpers for the frequency display slice.
package freq_disp_pkg;

  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} convState_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: IDLE -> LOAD -> 16x SHIFT -> COMMIT.
module bin2bcd_seq
  import freq_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] din,
  output logic [BIN_W-1:0] held,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  convState_t       stateQ, stateD;
  logic [BIN_W-1:0] shiftQ, shiftD;
  logic [BIN_W-1:0] heldQ, heldD;
  logic [BCD_W-1:0] bcdQ, bcdD;
  logic [BCD_W-1:0] bcdAdj;
  logic [3:0]       cntQ, cntD;
  logic             busyQ, busyD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      shiftQ <= '0;
      heldQ  <= '0;
      bcdQ   <= '0;
      cntQ   <= '0;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      shiftQ <= shiftD;
      heldQ  <= heldD;
      bcdQ   <= bcdD;
      cntQ   <= cntD;
      busyQ  <= busyD;
    end
  end

  always_comb begin
    stateD = stateQ;
    shiftD = shiftQ;
    heldD  = heldQ;
    bcdD   = bcdQ;
    cntD   = cntQ;
    busyD  = busyQ;
    bcdAdj = add3(bcdQ);
    unique case (stateQ)
      IDLE: begin
        if (start) stateD = LOAD;
      end
      LOAD: begin
        shiftD = din;
        heldD  = din;
        bcdD   = '0;
        cntD   = '0;
        busyD  = 1'b1;
        stateD = SHIFT;
      end
      SHIFT: begin
        {bcdD, shiftD} = {bcdAdj[BCD_W-2:0], shiftQ, 1'b0};
        cntD           = cntQ + 4'd1;
        if (cntQ == 4'd15) stateD = COMMIT;
      end
      COMMIT: begin
        busyD  = 1'b0;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  assign held = heldQ;
  assign busy = busyQ;
  assign done = (stateQ == COMMIT);
  assign bcd  = bcdQ;

endmodule

// File: rtl/freq_seg_display.sv
// Frequency reading to 4-digit multiplexed 7-segment display with Hz/kHz auto-ranging.
// Optional leading-zero blanking in Hz mode when FREQ_DISP_BLANK_EN is defined.
module freq_seg_display
  import freq_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 12500,
  parameter int unsigned CNT_W       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] freq,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             range_khz,
  output logic             busy
);

  logic [BIN_W-1:0] held;
  logic             convStart;
  logic             convDone;
  logic [BCD_W-1:0] bcd;

  assign convStart = (freq != held);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (convStart),
    .din   (freq),
    .held  (held),
    .busy  (busy),
    .done  (convDone),
    .bcd   (bcd)
  );

  logic [15:0]      dispQ;
  logic             khzQ;
  logic [CNT_W-1:0] preQ;
  logic [1:0]       idxQ;
  logic [6:0]       segQ, segD;
  logic             dpQ, dpD;
  logic [3:0]       anQ, anD;
  logic [3:0]       curDigit;
  logic             blankDigit;
  logic             termCnt;

  assign termCnt = (preQ == CNT_W'(REFRESH_DIV - 1));

  // Display registers only ever load a finished conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispQ <= '0;
      khzQ  <= 1'b0;
    end else if (convDone) begin
      if (bcd[19:16] != 4'd0) begin
        dispQ <= bcd[19:4];
        khzQ  <= 1'b1;
      end else begin
        dispQ <= bcd[15:0];
        khzQ  <= 1'b0;
      end
    end
  end

  always_comb begin
    curDigit   = 4'd0;
    blankDigit = 1'b0;
    case (idxQ)
      2'd0:    curDigit = dispQ[3:0];
      2'd1:    curDigit = dispQ[7:4];
      2'd2:    curDigit = dispQ[11:8];
      default: curDigit = dispQ[15:12];
    endcase
`ifdef FREQ_DISP_BLANK_EN
    if (!khzQ) begin
      case (idxQ)
        2'd3:    blankDigit = (dispQ[15:12] == 4'd0);
        2'd2:    blankDigit = (dispQ[15:8] == 8'd0);
        2'd1:    blankDigit = (dispQ[15:4] == 12'd0);
        default: blankDigit = 1'b0;
      endcase
    end
`endif
    segD = blankDigit ? SEG_BLANK : segDecode(curDigit);
    dpD  = !(khzQ && (idxQ == 2'd2));
    anD  = ~(4'b0001 << idxQ);
  end

  // seg/dp/an load together at terminal count so the digit and its pattern switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preQ <= '0;
      idxQ <= 2'd0;
      segQ <= SEG_BLANK;
      dpQ  <= 1'b1;
      anQ  <= 4'hF;
    end else if (termCnt) begin
      preQ <= '0;
      idxQ <= idxQ + 2'd1;
      segQ <= segD;
      dpQ  <= dpD;
      anQ  <= anD;
    end else begin
      preQ <= preQ + 1'b1;
    end
  end

  assign seg       = segQ;
  assign dp        = dpQ;
  assign an        = anQ;
  assign range_khz = khzQ;

endmodule
